// File: rtl/matrix_eltwise_seq.sv
// matrix_eltwise_seq
// Element-wise (Hadamard-style) operation on two HxW signed fixed-point
// matrices. One op per job (mul, add, sub, max), LANES elements per clock,
// saturated results.
//
// States
//   state | meaning
//   IDLE  | waiting for a job; in_ready=1
//   RUN   | computing LANES elements per edge, beat 0..BEATS-1
//   DONE  | result held on y/sat; out_valid=1 until out_ready
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_ready     job handshake carrying a, b, mode
//   mode                  00 mul, 01 add, 10 sub (a-b), 11 max
//   a, b                  element (r,c) at [(r*W+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready   result handshake
//   y                     result matrix, same layout as a
//   sat                   sticky: some element of this job was clamped
module matrix_eltwise_seq #(
  parameter int H           = 4,
  parameter int W           = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int ROUND       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   mode,
  input  logic [H*W*DATA_WIDTH-1:0]    a,
  input  logic [H*W*DATA_WIDTH-1:0]    b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [H*W*DATA_WIDTH-1:0]    y,
  output logic                         sat
);

  localparam int N     = H * W;
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] M_MUL = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_SUB = 2'b10;

  localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  // Half of one output LSB, added before the shift for round-half-up.
  localparam logic signed [PW-1:0] RND  =
    (ROUND != 0 && FRACT_WIDTH > 0) ? (PW'(1) << (FRACT_WIDTH - 1)) : '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N*DW-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic [1:0]       mode_q, mode_d;
  logic             sat_q, sat_d;
  logic [BW-1:0]    beat_q, beat_d;

  // Returns {clamped, saturated value}. The wide intermediate keeps the
  // full product / sum so the range check is exact.
  function automatic logic [DW:0] elem_op(input logic [1:0] m,
                                          input logic signed [DW-1:0] x,
                                          input logic signed [DW-1:0] z);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] r;
    logic                 clamp;
    logic [DW-1:0]        v;
    p = PW'(x) * PW'(z);
    case (m)
      M_MUL:   r = (p + RND) >>> FRACT_WIDTH;
      M_ADD:   r = PW'(x) + PW'(z);
      M_SUB:   r = PW'(x) - PW'(z);
      default: r = (x > z) ? PW'(x) : PW'(z);
    endcase
    clamp = 1'b0;
    v     = r[DW-1:0];
    if (r > SMAX) begin
      v     = SMAX[DW-1:0];
      clamp = 1'b1;
    end else if (r < SMIN) begin
      v     = SMIN[DW-1:0];
      clamp = 1'b1;
    end
    return {clamp, v};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    y_d     = y_q;
    sat_d   = sat_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          sat_d   = 1'b0;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          int            idx;
          logic [DW:0]   res;
          idx = int'(beat_q) * LANES + l;
          res = '0;
          // The last beat may be partial; lanes past the matrix end idle.
          if (idx < N) begin
            res = elem_op(mode_q, a_q[idx*DW +: DW], b_q[idx*DW +: DW]);
            y_d[idx*DW +: DW] = res[DW-1:0];
            if (res[DW]) sat_d = 1'b1;
          end
        end
        if (beat_q == BW'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign sat       = sat_q;

endmodule
